y_sig_misr: RTL

Y_SIG_MISR -- requirements
Module: y_sig_misr

---
 rtl/y_sig_misr.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/y_sig_misr.sv
// rtl/y_sig_misr.sv - multiple-input signature register over a wide result bus
//
// Compresses SAMPLES beats of the result vector y into a SIG_W-bit signature.
// Each accepted beat XOR-folds y into SIG_W bits. The running signature is
// shifted left one bit, reduced by POLY when its MSB was set, and XORed with
// the fold.
//
// Ports:
//   clk        in   single clock, all state changes on posedge
//   rst        in   synchronous active-high reset
//   start      in   begin a run (honoured in IDLE and DONE, ignored in RUN)
//   in_valid   in   y carries a sample this cycle
//   y          in   [DATA_W] result vector being compressed
//   busy       out  high while in RUN
//   done       out  high while in DONE
//   sig        out  [SIG_W] current signature
//   count      out  [16] samples accepted in the current run
//   expect_sig in   [SIG_W] reference signature  (only with Y_SIG_MISR_CMP_EN)
//   match      out  final sig == expect_sig       (only with Y_SIG_MISR_CMP_EN)
//
// Optional feature macro: Y_SIG_MISR_CMP_EN adds the expect_sig/match compare.

module y_sig_misr #(
  parameter int                DATA_W  = 199,
  parameter int                SIG_W   = 32,
  parameter logic [SIG_W-1:0]  POLY    = 32'h04C11DB7,
  parameter logic [SIG_W-1:0]  SEED    = 32'hFFFFFFFF,
  parameter int                SAMPLES = 21
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] y,
  output logic              busy,
  output logic              done,
  output logic [SIG_W-1:0]  sig,
  output logic [15:0]       count
`ifdef Y_SIG_MISR_CMP_EN
  ,
  input  logic [SIG_W-1:0]  expect_sig,
  output logic              match
`endif
);

  // y is zero-extended to a whole number of SIG_W slices before folding.
  localparam int NSL   = (DATA_W + SIG_W - 1) / SIG_W;
  localparam int EXT_W = NSL * SIG_W;

  // Index of the final beat, compared against count before the increment.
  localparam logic [15:0] LAST_IDX = 16'(SAMPLES - 1);

  // The encoding puts busy on bit 0 and done on bit 1. Both outputs are
  // therefore straight decodes of state flops.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t state;
  state_t state_next;

  logic [EXT_W-1:0] y_ext;
  logic [SIG_W-1:0] fold;
  logic [SIG_W-1:0] sig_next;
  logic             accept;
  logic             last_beat;
  logic             restart;

  // ------------------------------------------------------------------
  // Fold and signature step
  // ------------------------------------------------------------------
  always_comb begin
    y_ext             = '0;
    y_ext[DATA_W-1:0] = y;
  end

  always_comb begin
    fold = '0;
    for (int k = 0; k < NSL; k++) begin
      fold = fold ^ y_ext[k*SIG_W +: SIG_W];
    end
  end

  always_comb begin
    sig_next = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ fold;
  end

  // A beat is only taken in RUN. start is ignored in RUN, so a restart can
  // only come from IDLE or DONE, and any in_valid on that edge is dropped.
  assign accept    = (state == RUN) && in_valid;
  assign last_beat = accept && (count == LAST_IDX);
  assign restart   = (state != RUN) && start;

  // ------------------------------------------------------------------
  // FSM: state register
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ------------------------------------------------------------------
  // FSM: next-state logic
  // ------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start)     state_next = RUN;
      RUN:     if (last_beat) state_next = DONE;
      DONE:    if (start)     state_next = RUN;
      default:                state_next = IDLE;
    endcase
  end

  // ------------------------------------------------------------------
  // FSM: outputs (decoded from the state register)
  // ------------------------------------------------------------------
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // ------------------------------------------------------------------
  // Signature and beat counter
  // ------------------------------------------------------------------
  // count stops at SAMPLES because the FSM leaves RUN on that beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      sig   <= SEED;
      count <= '0;
    end else if (restart) begin
      sig   <= SEED;
      count <= '0;
    end else if (accept) begin
      sig   <= sig_next;
      count <= count + 16'd1;
    end
  end

`ifdef Y_SIG_MISR_CMP_EN
  // The compare uses sig_next, which is the value sig takes on the
  // DONE-entry edge. match then holds until the next start.
  always_ff @(posedge clk) begin
    if (rst) begin
      match <= 1'b0;
    end else if (restart) begin
      match <= 1'b0;
    end else if (last_beat) begin
      match <= (sig_next == expect_sig);
    end
  end
`endif

  // ------------------------------------------------------------------
  // Invariants
  // ------------------------------------------------------------------
  a_busy_done_excl : assert property (@(posedge clk) disable iff (rst)
    !(busy && done));

  a_count_bound : assert property (@(posedge clk) disable iff (rst)
    count <= 16'(SAMPLES));

  a_done_count : assert property (@(posedge clk) disable iff (rst)
    done |-> (count == 16'(SAMPLES)));

endmodule
